// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
// State encoding, default geometry and the rotating-priority pick function.
package mux_rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int DEF_N = 8;
    localparam int DEF_M = 8;

    // rr_pick works on a fixed-width view so it can serve any N up to MAX_N.
    localparam int MAX_N  = 64;
    localparam int PICK_W = $clog2(MAX_N);

    function automatic int unsigned rr_pick(
        input logic [MAX_N-1:0] valid,
        input int unsigned      n,
        input int unsigned      ptr
    );
        int unsigned pick;
        int unsigned idx;
        logic        found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (!found && (i < n)) begin
                idx = ptr + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (valid[idx[PICK_W-1:0]]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// Combinational N-to-1 channel mux over a packed bus; zero latency, no flow control.
// Out-of-range selects return zero.
module mux_nto1 #(
    parameter int N  = 8,
    parameter int M  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic [N*M-1:0] data_i,
    input  logic [SW-1:0]  sel_i,
    output logic [M-1:0]   data_o
);

    always_comb begin
        data_o = '0;
        for (int k = 0; k < N; k++) begin
            if (sel_i == SW'(k)) begin
                data_o = data_i[k*M +: M];
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Per-packet round-robin arbiter driving the channel mux select; 1-cycle registered output.
// Backpressure: o_ready is all-zero while the output register holds a beat that i_ready has not taken.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int M = DEF_M
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N-1:0]      i_valid,
    input  logic [N-1:0]      i_last,
    input  logic [N*M-1:0]    i_data,
    output logic [N-1:0]      o_ready,
    output logic              o_valid,
    output logic [M-1:0]      o_data,
    output logic              o_last,
    output logic [$clog2(N)-1:0] o_sel,
    input  logic              i_ready
);

    localparam int SW = $clog2(N);

    arb_state_e      state_q, state_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   lock_q, lock_d;
    logic            valid_q;
    logic [M-1:0]    data_q;
    logic            last_q;
    logic [SW-1:0]   sel_q;

    logic            can_load;
    logic            any_vld;
    logic [SW-1:0]   grant;
    logic [N-1:0]    grant_oh;
    logic [M-1:0]    mux_dat;
    logic            xfer;
    logic [SW-1:0]   grant_nxt;
    logic [MAX_N-1:0] vld_pad;

    assign can_load  = !valid_q || i_ready;
    assign any_vld   = |i_valid;
    assign vld_pad   = MAX_N'(i_valid);
    assign grant     = (state_q == LOCK) ? lock_q
                                         : SW'(rr_pick(vld_pad, N, 32'(ptr_q)));
    assign grant_oh  = N'(1) << grant;
    assign grant_nxt = (grant == SW'(N-1)) ? '0 : grant + 1'b1;

    mux_nto1 #(
        .N  (N),
        .M  (M),
        .SW (SW)
    ) u_mux (
        .data_i (i_data),
        .sel_i  (grant),
        .data_o (mux_dat)
    );

    // Ready is combinational on i_valid and i_ready so packets and channels switch without bubbles.
    always_comb begin
        o_ready = '0;
        if (i_rst_n && can_load) begin
            if (state_q == IDLE) begin
                if (any_vld) begin
                    o_ready = grant_oh;
                end
            end else if (i_valid[lock_q]) begin
                o_ready = grant_oh;
            end
        end
    end

    assign xfer = |(i_valid & o_ready);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        if (xfer) begin
            if (i_last[grant]) begin
                state_d = IDLE;
                ptr_d   = grant_nxt;
            end else begin
                state_d = LOCK;
                lock_d  = grant;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lock_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            if (xfer) begin
                valid_q <= 1'b1;
                data_q  <= mux_dat;
                last_q  <= i_last[grant];
                sel_q   <= grant;
            end else if (can_load) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_last  = last_q;
    assign o_sel   = sel_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter at N=8, M=8 with a fixed channel data pattern.
module tb_mux_rr_arbiter;

    localparam int N  = 8;
    localparam int M  = 8;
    localparam int SW = 3;

    logic           i_clk = 1'b0;
    logic           i_rst_n;
    logic [N-1:0]   i_valid;
    logic [N-1:0]   i_last;
    logic [N*M-1:0] i_data;
    logic [N-1:0]   o_ready;
    logic           o_valid;
    logic [M-1:0]   o_data;
    logic           o_last;
    logic [SW-1:0]  o_sel;
    logic           i_ready;

    int compared = 0;
    int mismatched = 0;

    // Channel data for 64'hABCD_EFAB_CDEF_ABCD, channels 0..7.
    logic [7:0] ch_dat [8] = '{8'hCD, 8'hAB, 8'hEF, 8'hCD, 8'hAB, 8'hEF, 8'hCD, 8'hAB};

    always #5 i_clk = ~i_clk;

    mux_rr_arbiter #(.N(N), .M(M)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .i_last  (i_last),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_sel   (o_sel),
        .i_ready (i_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input int sel, input logic last);
        chk({tag, ".valid"}, 64'(o_valid), 64'd1);
        chk({tag, ".sel"},   64'(o_sel),   64'(sel));
        chk({tag, ".data"},  64'(o_data),  64'(ch_dat[sel]));
        chk({tag, ".last"},  64'(o_last),  64'(last));
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_valid = 8'hFF;
        i_last  = 8'hFF;
        i_ready = 1'b1;
        i_data  = 64'hABCD_EFAB_CDEF_ABCD;

        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst.valid", 64'(o_valid), 64'd0);
            chk("rst.data",  64'(o_data),  64'd0);
            chk("rst.sel",   64'(o_sel),   64'd0);
            chk("rst.ready", 64'(o_ready), 64'd0);
        end

        // Fair rotation across all eight channels, then wrap to ch0.
        i_rst_n = 1'b1;
        #1;
        chk("rot.ready0", 64'(o_ready), 64'h01);
        chk("rot.valid0", 64'(o_valid), 64'd0);
        for (int k = 0; k < 9; k++) begin
            tick();
            chk_beat("rot", k % 8, 1'b1);
        end

        // ch2 3-beat packet vs ch5 single beats; ptr=1 so ch2 wins first.
        i_valid = 8'h24;
        i_last  = 8'h20;
        tick();
        chk_beat("lock.b1", 2, 1'b0);
        chk("lock.ready", 64'(o_ready), 64'h04);
        tick();
        chk_beat("lock.b2", 2, 1'b0);
        i_last = 8'h24;
        tick();
        chk_beat("lock.b3", 2, 1'b1);
        tick();
        chk_beat("lock.ch5", 5, 1'b1);

        // Backpressure with ch3 held in the output register; ptr=6 so ch3 wins over ch4.
        i_valid = 8'h18;
        i_last  = 8'hFF;
        tick();
        chk_beat("bp.load", 3, 1'b1);
        i_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("bp.ready", 64'(o_ready), 64'h00);
            tick();
            chk_beat("bp.hold", 3, 1'b1);
        end
        i_ready = 1'b1;
        #1;
        chk("bp.rel.ready", 64'(o_ready), 64'h10);
        tick();
        chk_beat("bp.ch4", 4, 1'b1);
        tick();
        chk_beat("bp.ch3", 3, 1'b1);

        // Wrap: ch6 leaves ptr=7, then ch7 before ch1.
        i_valid = 8'h40;
        tick();
        chk_beat("wrap.ch6", 6, 1'b1);
        i_valid = 8'h82;
        tick();
        chk_beat("wrap.ch7", 7, 1'b1);
        tick();
        chk_beat("wrap.ch1", 1, 1'b1);

        // Reset during beat 2 of a 4-beat ch3 packet.
        i_valid = 8'h08;
        i_last  = 8'h00;
        tick();
        chk_beat("mrst.b1", 3, 1'b0);
        i_rst_n = 1'b0;
        #1;
        chk("mrst.ready", 64'(o_ready), 64'h00);
        tick();
        chk("mrst.valid", 64'(o_valid), 64'd0);
        chk("mrst.sel",   64'(o_sel),   64'd0);
        i_rst_n = 1'b1;
        i_valid = 8'h09;
        i_last  = 8'hFF;
        #1;
        chk("mrst.ready.post", 64'(o_ready), 64'h01);
        tick();
        chk_beat("mrst.ch0", 0, 1'b1);
        tick();
        chk_beat("mrst.ch3", 3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
